m_lsu: RTL and testbench

//   Memory-stage load/store unit: initiator side of the word-wide data-memory port (DM).

---
 rtl/m_lsu.sv | 171 +++++++++++++++++
 tb/tb_m_lsu.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_lsu.sv
// m_lsu: memory-stage load/store unit driving a word-wide data memory; SB/SH use read-modify-write.
// Optional macro LSU_ALIGN_EXC_EN enables alignment/range error responses.
module m_lsu #(
  parameter int unsigned OP_W     = 3,
  parameter logic [31:0] ADDR_LIM = 32'h0000_3FFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [31:0]     req_pc,
  output logic            busy,
  output logic            resp_valid,
  output logic [31:0]     resp_data,
  output logic            resp_err,
  output logic [31:0]     dm_addr,
  output logic            dm_we,
  output logic [31:0]     dm_wdata,
  output logic [31:0]     dm_pc,
  input  logic [31:0]     dm_rdata
);

  localparam logic [OP_W-1:0] OpLw  = OP_W'(0);
  localparam logic [OP_W-1:0] OpLh  = OP_W'(1);
  localparam logic [OP_W-1:0] OpLhu = OP_W'(2);
  localparam logic [OP_W-1:0] OpLb  = OP_W'(3);
  localparam logic [OP_W-1:0] OpLbu = OP_W'(4);
  localparam logic [OP_W-1:0] OpSw  = OP_W'(5);
  localparam logic [OP_W-1:0] OpSh  = OP_W'(6);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [31:0]     addr_q, wdata_q, pc_q, wbuf_q;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            accept, resp_upd, wbuf_upd, req_err, is_load;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     load_val, merged;

`ifdef LSU_ALIGN_EXC_EN
  logic word_op, half_op;
  always_comb begin
    word_op = (req_op == OpLw) || (req_op == OpSw);
    half_op = (req_op == OpLh) || (req_op == OpLhu) || (req_op == OpSh);
    req_err = (req_addr > ADDR_LIM) || (word_op && (req_addr[1:0] != 2'b00)) ||
              (half_op && req_addr[0]);
  end
`else
  logic unused_addr_lim;
  assign unused_addr_lim = ^ADDR_LIM;
  assign req_err = 1'b0;
`endif

  // Lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    is_load = (op_q < OpSw);
    lane_b  = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h  = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OpLw:    load_val = dm_rdata;
      OpLh:    load_val = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_val = {16'h0000, lane_h};
      OpLb:    load_val = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_val = {24'h000000, lane_b};
      default: load_val = 32'h0;
    endcase
    merged = dm_rdata;
    if (op_q == OpSh) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else              merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    resp_upd    = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = 1'b0;
    wbuf_upd    = 1'b0;
    req_ready   = 1'b0;
    dm_addr     = 32'h0;
    dm_we       = 1'b0;
    dm_wdata    = 32'h0;
    dm_pc       = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_d     = StDone;
            resp_upd    = 1'b1;
            resp_data_d = 32'h0;
            resp_err_d  = 1'b1;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        dm_addr = {addr_q[31:2], 2'b00};
        dm_pc   = pc_q;
        if (is_load) begin
          resp_upd    = 1'b1;
          resp_data_d = load_val;
          state_d     = StDone;
        end else if (op_q == OpSw) begin
          dm_we       = 1'b1;
          dm_wdata    = wdata_q;
          resp_upd    = 1'b1;
          resp_data_d = 32'h0;
          state_d     = StDone;
        end else begin
          wbuf_upd = 1'b1;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        dm_addr     = {addr_q[31:2], 2'b00};
        dm_pc       = pc_q;
        dm_we       = 1'b1;
        dm_wdata    = wbuf_q;
        resp_upd    = 1'b1;
        resp_data_d = 32'h0;
        state_d     = StDone;
      end
      StDone: begin
        dm_pc   = pc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      pc_q        <= 32'h0;
      wbuf_q      <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
      if (wbuf_upd) wbuf_q <= merged;
      if (resp_upd) begin
        resp_data_q <= resp_data_d;
        resp_err_q  <= resp_err_d;
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: self-checking bench for m_lsu with a behavioural data-memory and load/store model.
// Honours LSU_ALIGN_EXC_EN the same way as the design.
module tb_m_lsu;

`ifdef LSU_ALIGN_EXC_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        busy, resp_valid, resp_err, dm_we;
  logic [31:0] resp_data, dm_addr, dm_wdata, dm_pc, dm_rdata;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int n_checks = 0;
  int n_pass   = 0;

  m_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_we      (dm_we),
    .dm_wdata   (dm_wdata),
    .dm_pc      (dm_pc),
    .dm_rdata   (dm_rdata)
  );

  always #5 clk = ~clk;
  assign dm_rdata = mem[dm_addr[5:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[5:2]] <= dm_wdata;

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w,
                                           input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (32'(a[1:0]) * 8)) & 32'hFF;
    h = (w >> (32'(a[1]) * 16)) & 32'hFFFF;
    case (op)
      3'd0:    return w;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] w,
                                            input logic [31:0] a, input logic [31:0] d);
    int unsigned sh;
    case (op)
      3'd6: begin
        sh = 32'(a[1]) * 16;
        return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      3'd7: begin
        sh = 32'(a[1:0]) * 8;
        return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      default: return d;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op, input logic [31:0] a);
    logic word_op, half_op;
    word_op = (op == 3'd0) || (op == 3'd5);
    half_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd6);
    return AlignChk && ((a > 32'h3FFF) || (word_op && (a % 4 != 0)) || (half_op && (a % 2 != 0)));
  endfunction

  // Issue one request and observe it until resp_valid; cycle 1 is the cycle after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] pc, output logic [31:0] rdata, output logic err,
                        output int lat, output int we_cnt, output int we_at,
                        output logic [31:0] we_data, output logic [31:0] we_addr,
                        output logic [31:0] pc_seen);
    int n;
    lat = -1; we_cnt = 0; we_at = -1; we_data = 0; we_addr = 0; rdata = 0; err = 0;
    pc_seen = 0;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_pc = pc; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    for (n = 1; n <= 8; n++) begin
      if (n == 1) pc_seen = dm_pc;
      if (dm_we) begin we_cnt++; we_at = n; we_data = dm_wdata; we_addr = dm_addr; end
      if (resp_valid) begin lat = n; rdata = resp_data; err = resp_err; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 0; req_wdata = 0; req_pc = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, busy, resp_valid, resp_err, dm_we} !== 5'b10000)
      $display("FAIL reset_ctrl got %b want 10000", {req_ready, busy, resp_valid, resp_err, dm_we});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_data, dm_addr, dm_wdata, dm_pc} !== 128'h0)
      $display("FAIL reset_data got %h want 0", {resp_data, dm_addr, dm_wdata, dm_pc});
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] rd, wd, wa, pcs;
    logic er;
    int lat, wc, wt;
    logic [2:0]  lop [5] = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
    logic [31:0] lad [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] lex [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                             32'h0000BEEF};
    run_op(3'd5, 32'h10, 32'hDEADBEEF, 32'h100, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (wt !== 1 || wa !== 32'h10 || wd !== 32'hDEADBEEF)
      $display("FAIL sw_write got at=%0d addr=%h data=%h want at=1 addr=10 data=deadbeef",
               wt, wa, wd);
    else n_pass++;
    n_checks++;
    if (lat !== 2 || rd !== 32'h0) $display("FAIL sw_resp got lat=%0d data=%h want 2/0", lat, rd);
    else n_pass++;
    n_checks++;
    if (pcs !== 32'h100) $display("FAIL sw_pc got %h want 00000100", pcs);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      run_op(lop[i], lad[i], 32'h0, 32'h200, rd, er, lat, wc, wt, wd, wa, pcs);
      n_checks++;
      if (rd !== lex[i] || lat !== 2 || wc !== 0)
        $display("FAIL load_%0d got data=%h lat=%0d we=%0d want %h/2/0", i, rd, lat, wc, lex[i]);
      else n_pass++;
    end
    run_op(3'd7, 32'h11, 32'h12345677, 32'h300, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (wc !== 1 || wt !== 2 || wd !== 32'hDEAD77EF || lat !== 3)
      $display("FAIL sb_rmw got we=%0d at=%0d data=%h lat=%0d want 1/2/dead77ef/3",
               wc, wt, wd, lat);
    else n_pass++;
    run_op(3'd6, 32'h12, 32'hAAAA5555, 32'h304, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (wc !== 1 || wd !== 32'h555577EF || lat !== 3)
      $display("FAIL sh_rmw got we=%0d data=%h lat=%0d want 1/555577ef/3", wc, wd, lat);
    else n_pass++;
    run_op(3'd0, 32'h10, 32'h0, 32'h308, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (rd !== 32'h555577EF) $display("FAIL lw_after_rmw got %h want 555577ef", rd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dm_addr !== 32'h0 || dm_we !== 1'b0 || dm_pc !== 32'h0)
      $display("FAIL idle_dm got addr=%h we=%b pc=%h want 0", dm_addr, dm_we, dm_pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, wd, wa, pcs;
    logic er;
    int lat, wc, wt, seen;
    run_op(3'd5, 32'h10, 32'hDEADBEEF, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
    @(negedge clk);
    req_op = 3'd7; req_addr = 32'h11; req_wdata = 32'h12345677; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dm_we !== 1'b1) $display("FAIL mid_write_phase got we=%b want 1", dm_we);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dm_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset_drop got we=%b busy=%b want 0/0", dm_we, busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", req_ready);
    else n_pass++;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL mid_no_resp got %0d pulses want 0", seen);
    else n_pass++;
    run_op(3'd0, 32'h10, 32'h0, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (rd !== 32'hDEADBEEF) $display("FAIL mid_word_kept got %h want deadbeef", rd);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, wd, wa, pcs;
    logic er;
    int lat, wc, wt;
    run_op(3'd0, 32'h12, 32'h0, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
`ifdef LSU_ALIGN_EXC_EN
    n_checks++;
    if (lat !== 1 || er !== 1'b1 || wc !== 0 || rd !== 32'h0)
      $display("FAIL lw_misalign got lat=%0d err=%b we=%0d data=%h want 1/1/0/0", lat, er, wc, rd);
    else n_pass++;
    run_op(3'd5, 32'h4000, 32'h1, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (lat !== 1 || er !== 1'b1 || wc !== 0)
      $display("FAIL sw_range got lat=%0d err=%b we=%0d want 1/1/0", lat, er, wc);
    else n_pass++;
`else
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL lw_misalign got lat=%0d err=%b data=%h want 2/0/deadbeef", lat, er, rd);
    else n_pass++;
    run_op(3'd1, 32'h13, 32'h0, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (rd !== 32'hFFFFDEAD || er !== 1'b0)
      $display("FAIL lh_odd got data=%h err=%b want ffffdead/0", rd, er);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd, wa, pcs;
    logic er;
    int lat, wc, wt, sent, we_n, bad_busy;
    int we_cyc [3];
    logic prev_we;
    sent = 0; we_n = 0; bad_busy = 0; prev_we = 1'b0;
    we_cyc = '{-100, -100, -100};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dm_we) begin
        if (we_n < 3) we_cyc[we_n] = c;
        we_n++;
      end
      if ((dm_we || prev_we) && !busy) bad_busy++;
      prev_we = dm_we;
      if (req_ready) begin
        if (sent < 3) begin
          req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h20;
          req_wdata = 32'hA000_0000 + 32'(sent); req_pc = 32'h400;
          sent++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (we_n !== 3) $display("FAIL b2b_count got %0d want 3", we_n);
    else n_pass++;
    n_checks++;
    if (we_cyc[1] - we_cyc[0] !== 3 || we_cyc[2] - we_cyc[1] !== 3)
      $display("FAIL b2b_spacing got %0d,%0d want 3,3", we_cyc[1] - we_cyc[0],
               we_cyc[2] - we_cyc[1]);
    else n_pass++;
    n_checks++;
    if (bad_busy !== 0) $display("FAIL b2b_busy got %0d low cycles want 0", bad_busy);
    else n_pass++;
    run_op(3'd0, 32'h20, 32'h0, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
    n_checks++;
    if (rd !== 32'hA000_0002) $display("FAIL b2b_last got %h want a0000002", rd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, wa, pcs, a, d, w, exp_w;
    logic [2:0] op;
    logic er, exp_err;
    int lat, wc, wt, exp_lat, exp_wc;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run_op(3'd5, 32'(i * 4), d, 32'h0, rd, er, lat, wc, wt, wd, wa, pcs);
      ref_mem[i] = d;
    end
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      d  = $urandom;
      w  = ref_mem[a[5:2]];
      exp_err = ref_err(op, a);
      exp_lat = exp_err ? 1 : (op >= 3'd6) ? 3 : 2;
      exp_wc  = (exp_err || op < 3'd5) ? 0 : 1;
      run_op(op, a, d, 32'(i), rd, er, lat, wc, wt, wd, wa, pcs);
      n_checks++;
      if (lat !== exp_lat || er !== exp_err || wc !== exp_wc)
        $display("FAIL rnd_ctrl op=%0d a=%h got lat=%0d err=%b we=%0d want %0d/%b/%0d",
                 op, a, lat, er, wc, exp_lat, exp_err, exp_wc);
      else n_pass++;
      n_checks++;
      if (rd !== ((exp_err || op >= 3'd5) ? 32'h0 : ref_load(op, w, a)))
        $display("FAIL rnd_rdata op=%0d a=%h got %h want %h", op, a, rd,
                 (exp_err || op >= 3'd5) ? 32'h0 : ref_load(op, w, a));
      else n_pass++;
      if (op >= 3'd5 && !exp_err) begin
        exp_w = ref_store(op, w, a, d);
        ref_mem[a[5:2]] = exp_w;
        n_checks++;
        if (wd !== exp_w || wa !== {a[31:2], 2'b00})
          $display("FAIL rnd_store op=%0d a=%h got %h@%h want %h", op, a, wd, wa, exp_w);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
